// File: rtl/if_fetch_unit_if.sv
// if_fetch_unit_if: instruction-memory read port between the fetch stage and imem
//
// Signals:
//   req    fetch -> imem  read request, held with addr until ack
//   addr   fetch -> imem  32-bit read address
//   ack    imem  -> fetch read data valid this cycle (may coincide with req rising)
//   rdata  imem  -> fetch 32-bit read data, meaningful only while ack=1
// Modports: master = fetch unit, slave = instruction memory.
interface if_fetch_unit_if;
    logic        req;
    logic [31:0] addr;
    logic        ack;
    logic [31:0] rdata;
    modport master (output req, output addr, input ack, input rdata);
    modport slave  (input req, input addr, output ack, output rdata);
endinterface

// File: rtl/if_fetch_unit.sv
// if_fetch_unit: MIPS IF stage, owns fetch PC, one outstanding imem read, one-entry skid, redirect drain
//
// Parameters:
//   RESET_PC       first fetch address after reset
//   NOP            instruction word shown while valid_o=0
// Ports:
//   clk_i          clock, rising edge
//   rst_i          asynchronous active-low reset
//   hazard_i       IF/ID stall: output slot is not consumed this cycle
//   redirect_i     taken branch/jump, discards the sequential path
//   redirect_pc_i  redirect target
//   imem           instruction-memory read port (master side)
//   instruction_o  fetched word to IF/ID (NOP when invalid)
//   pc_add4_o      fetch address + 4 of instruction_o
//   valid_o        output slot holds a real instruction
module if_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP      = 32'h0000_0000
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  hazard_i,
    input  logic                  redirect_i,
    input  logic [31:0]           redirect_pc_i,
    if_fetch_unit_if.master       imem,
    output logic [31:0]           instruction_o,
    output logic [31:0]           pc_add4_o,
    output logic                  valid_o
);
    // FETCH: request outstanding; HOLD: skid full, no request; DRAIN: stale request after redirect
    typedef enum logic [1:0] {FETCH, HOLD, DRAIN} state_t;
    state_t      state_q, state_d;
    logic [31:0] req_addr_q, redir_pc_q, skid_instr_q, skid_pc4_q, instr_q, pc4_q;
    logic        valid_q;
    logic [31:0] req_pc4, req_addr_d;
    logic        slot_free, fetch_ack, drain_ack, redir_now, take_data, to_skid, bubble, unskid;
    assign req_pc4   = req_addr_q + 32'd4;
    assign slot_free = !valid_q || !hazard_i;
    assign fetch_ack = (state_q == FETCH) && imem.ack;
    assign drain_ack = (state_q == DRAIN) && imem.ack;
    // A redirect can retarget immediately only when no request is left in flight after this edge
    assign redir_now = redirect_i && ((state_q == HOLD) || fetch_ack || drain_ack);
    assign take_data = !redirect_i && fetch_ack && slot_free;
    assign to_skid   = !redirect_i && fetch_ack && !slot_free;
    assign bubble    = !redirect_i && (state_q == FETCH) && !imem.ack && slot_free;
    assign unskid    = !redirect_i && (state_q == HOLD) && !hazard_i;
    assign req_addr_d = redir_now                 ? redirect_pc_i :
                        (fetch_ack && !redirect_i) ? req_pc4 :
                        (drain_ack && !redirect_i) ? redir_pc_q : req_addr_q;
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) state_q <= FETCH;
        else        state_q <= state_d;
    end
    always_comb begin
        state_d = state_q;
        case (state_q)
            FETCH:   state_d = redirect_i ? (imem.ack ? FETCH : DRAIN) : (to_skid ? HOLD : FETCH);
            HOLD:    state_d = (redirect_i || !hazard_i) ? FETCH : HOLD;
            DRAIN:   state_d = imem.ack ? FETCH : DRAIN;
            default: state_d = FETCH;
        endcase
    end
    // Request is gated by reset so it drops the moment reset asserts and rises on release
    always_comb begin
        imem.req  = rst_i && (state_q != HOLD);
        imem.addr = req_addr_q;
    end
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            req_addr_q   <= RESET_PC;
            redir_pc_q   <= 32'd0;
            skid_instr_q <= 32'd0;
            skid_pc4_q   <= 32'd0;
            instr_q      <= NOP;
            pc4_q        <= 32'd0;
            valid_q      <= 1'b0;
        end else begin
            req_addr_q <= req_addr_d;
            if (redirect_i && !redir_now) redir_pc_q <= redirect_pc_i;
            if (to_skid) begin
                skid_instr_q <= imem.rdata;
                skid_pc4_q   <= req_pc4;
            end
            if (redirect_i || bubble) begin
                valid_q <= 1'b0;
                instr_q <= NOP;
            end else if (take_data) begin
                valid_q <= 1'b1;
                instr_q <= imem.rdata;
                pc4_q   <= req_pc4;
            end else if (unskid) begin
                valid_q <= 1'b1;
                instr_q <= skid_instr_q;
                pc4_q   <= skid_pc4_q;
            end
        end
    end
    assign instruction_o = instr_q;
    assign pc_add4_o     = pc4_q;
    assign valid_o       = valid_q;
endmodule

// File: tb/tb_if_fetch_unit.sv
// tb_if_fetch_unit: directed and randomized checks of if_fetch_unit against a stream-level model
module tb_if_fetch_unit;
    logic        clk = 1'b0;
    logic        rst_i = 1'b0;
    logic        hazard_i = 1'b0;
    logic        redirect_i = 1'b0;
    logic [31:0] redirect_pc_i = 32'd0;
    logic [31:0] instruction_o, pc_add4_o;
    logic        valid_o;
    if_fetch_unit_if imem();
    if_fetch_unit dut (
        .clk_i(clk), .rst_i(rst_i), .hazard_i(hazard_i), .redirect_i(redirect_i),
        .redirect_pc_i(redirect_pc_i), .imem(imem),
        .instruction_o(instruction_o), .pc_add4_o(pc_add4_o), .valid_o(valid_o)
    );
    always #5 clk = ~clk;
    int n_checks = 0;
    int n_pass = 0;
    int lat = 0;
    int cnt = 0;
    bit rand_lat = 1'b0;
    bit dead_en = 1'b0;
    bit last_ack = 1'b0;
    logic [31:0] exp_pc;
    function automatic logic [31:0] memf(input logic [31:0] a);
        return a * 32'h9E37_79B1 + 32'h0123_4567;
    endfunction
    // Memory model: acks after lat waiting cycles, decided just after the falling edge
    task automatic tick();
        #1;
        if (!imem.req) begin
            cnt = 0; imem.ack = 1'b0; imem.rdata = $urandom;
        end else if (cnt >= lat) begin
            imem.ack = 1'b1;
            imem.rdata = (dead_en && imem.addr == 32'h20) ? 32'hDEAD_BEEF : memf(imem.addr);
            cnt = 0;
            if (rand_lat) lat = $urandom_range(0, 3);
        end else begin
            imem.ack = 1'b0; imem.rdata = $urandom; cnt++;
        end
        last_ack = imem.ack;
        @(posedge clk);
        @(negedge clk);
    endtask
    task automatic test_reset();
        imem.ack = 1'b0; imem.rdata = 32'd0;
        repeat (2) @(negedge clk);
        n_checks++; if (imem.req !== 1'b0) $display("FAIL reset_req got=%0h exp=0", imem.req); else n_pass++;
        n_checks++; if (valid_o !== 1'b0) $display("FAIL reset_valid got=%0h exp=0", valid_o); else n_pass++;
        n_checks++; if (instruction_o !== 32'h0) $display("FAIL reset_instr got=%h exp=0", instruction_o); else n_pass++;
        n_checks++; if (pc_add4_o !== 32'h0) $display("FAIL reset_pc4 got=%h exp=0", pc_add4_o); else n_pass++;
        n_checks++; if (imem.addr !== 32'h0) $display("FAIL reset_addr got=%h exp=0", imem.addr); else n_pass++;
        rst_i = 1'b1;
        #1;
        n_checks++; if (imem.req !== 1'b1) $display("FAIL release_req got=%0h exp=1", imem.req); else n_pass++;
    endtask
    task automatic test_stream();
        lat = 0;
        for (int k = 1; k <= 3; k++) begin
            tick();
            n_checks++; if (valid_o !== 1'b1) $display("FAIL stream_valid k=%0d got=%0h exp=1", k, valid_o); else n_pass++;
            n_checks++; if (imem.addr !== 32'(4 * k)) $display("FAIL stream_addr k=%0d got=%h exp=%h", k, imem.addr, 32'(4 * k)); else n_pass++;
            n_checks++; if (pc_add4_o !== 32'(4 * k)) $display("FAIL stream_pc4 k=%0d got=%h exp=%h", k, pc_add4_o, 32'(4 * k)); else n_pass++;
            n_checks++; if (instruction_o !== memf(32'(4 * (k - 1)))) $display("FAIL stream_instr k=%0d got=%h exp=%h", k, instruction_o, memf(32'(4 * (k - 1)))); else n_pass++;
        end
    endtask
    task automatic test_stall();
        hazard_i = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            n_checks++; if (imem.req !== 1'b0) $display("FAIL stall_req k=%0d got=%0h exp=0", k, imem.req); else n_pass++;
            n_checks++; if (valid_o !== 1'b1 || instruction_o !== memf(32'h8) || pc_add4_o !== 32'hC)
                $display("FAIL stall_hold k=%0d got=%0h/%h/%h exp=1/%h/0000000c", k, valid_o, instruction_o, pc_add4_o, memf(32'h8));
            else n_pass++;
        end
        hazard_i = 1'b0;
        tick();
        n_checks++; if (valid_o !== 1'b1 || instruction_o !== memf(32'hC) || pc_add4_o !== 32'h10)
            $display("FAIL stall_skid got=%0h/%h/%h exp=1/%h/00000010", valid_o, instruction_o, pc_add4_o, memf(32'hC));
        else n_pass++;
        n_checks++; if (imem.req !== 1'b1 || imem.addr !== 32'h10) $display("FAIL stall_resume_addr got=%0h/%h exp=1/00000010", imem.req, imem.addr); else n_pass++;
        tick();
        n_checks++; if (instruction_o !== memf(32'h10) || pc_add4_o !== 32'h14)
            $display("FAIL stall_next got=%h/%h exp=%h/00000014", instruction_o, pc_add4_o, memf(32'h10));
        else n_pass++;
    endtask
    task automatic test_latency();
        int nvalid = 0;
        lat = 2;
        exp_pc = 32'h14;
        for (int k = 0; k < 9; k++) begin
            tick();
            if (valid_o) begin
                nvalid++;
                n_checks++; if (instruction_o !== memf(exp_pc) || pc_add4_o !== exp_pc + 32'd4)
                    $display("FAIL lat_word got=%h/%h exp=%h/%h", instruction_o, pc_add4_o, memf(exp_pc), exp_pc + 32'd4);
                else n_pass++;
                exp_pc += 32'd4;
            end else begin
                n_checks++; if (instruction_o !== 32'h0) $display("FAIL lat_bubble got=%h exp=0", instruction_o); else n_pass++;
            end
        end
        n_checks++; if (nvalid != 3) $display("FAIL lat_count got=%0d exp=3", nvalid); else n_pass++;
    endtask
    task automatic test_redirect_drain();
        lat = 0;
        redirect_i = 1'b1; redirect_pc_i = 32'h20;
        tick();
        redirect_i = 1'b0;
        n_checks++; if (valid_o !== 1'b0 || imem.addr !== 32'h20) $display("FAIL redir_ack got=%0h/%h exp=0/00000020", valid_o, imem.addr); else n_pass++;
        lat = 2; dead_en = 1'b1;
        redirect_i = 1'b1; redirect_pc_i = 32'h100;
        tick();
        redirect_i = 1'b0;
        for (int k = 0; k < 2; k++) begin
            n_checks++; if (imem.req !== 1'b1 || imem.addr !== 32'h20 || valid_o !== 1'b0)
                $display("FAIL drain_wait k=%0d got=%0h/%h/%0h exp=1/00000020/0", k, imem.req, imem.addr, valid_o);
            else n_pass++;
            tick();
        end
        n_checks++; if (imem.addr !== 32'h100 || valid_o !== 1'b0 || instruction_o !== 32'h0)
            $display("FAIL drain_done got=%h/%0h/%h exp=00000100/0/0", imem.addr, valid_o, instruction_o);
        else n_pass++;
        lat = 0; dead_en = 1'b0;
        tick();
        n_checks++; if (valid_o !== 1'b1 || instruction_o !== memf(32'h100) || pc_add4_o !== 32'h104)
            $display("FAIL drain_target got=%0h/%h/%h exp=1/%h/00000104", valid_o, instruction_o, pc_add4_o, memf(32'h100));
        else n_pass++;
    endtask
    task automatic test_redirect_hold();
        hazard_i = 1'b1;
        tick();
        n_checks++; if (imem.req !== 1'b0 || instruction_o !== memf(32'h100)) $display("FAIL hold_enter got=%0h/%h exp=0/%h", imem.req, instruction_o, memf(32'h100)); else n_pass++;
        redirect_i = 1'b1; redirect_pc_i = 32'h200;
        tick();
        redirect_i = 1'b0;
        n_checks++; if (valid_o !== 1'b0 || instruction_o !== 32'h0 || imem.req !== 1'b1 || imem.addr !== 32'h200)
            $display("FAIL hold_redir got=%0h/%h/%0h/%h exp=0/0/1/00000200", valid_o, instruction_o, imem.req, imem.addr);
        else n_pass++;
        hazard_i = 1'b0;
        tick();
        n_checks++; if (valid_o !== 1'b1 || instruction_o !== memf(32'h200) || pc_add4_o !== 32'h204)
            $display("FAIL hold_target got=%0h/%h/%h exp=1/%h/00000204", valid_o, instruction_o, pc_add4_o, memf(32'h200));
        else n_pass++;
    endtask
    task automatic test_wrap();
        redirect_i = 1'b1; redirect_pc_i = 32'hFFFF_FFFC;
        tick();
        redirect_i = 1'b0;
        n_checks++; if (imem.addr !== 32'hFFFF_FFFC) $display("FAIL wrap_addr got=%h exp=fffffffc", imem.addr); else n_pass++;
        tick();
        n_checks++; if (pc_add4_o !== 32'h0 || instruction_o !== memf(32'hFFFF_FFFC) || imem.addr !== 32'h0)
            $display("FAIL wrap_pc4 got=%h/%h/%h exp=0/%h/0", pc_add4_o, instruction_o, imem.addr, memf(32'hFFFF_FFFC));
        else n_pass++;
    endtask
    task automatic test_reset_mid();
        redirect_i = 1'b1; redirect_pc_i = 32'h300;
        tick();
        redirect_i = 1'b0;
        lat = 3;
        tick();
        n_checks++; if (imem.req !== 1'b1 || imem.addr !== 32'h300) $display("FAIL rmid_wait got=%0h/%h exp=1/00000300", imem.req, imem.addr); else n_pass++;
        rst_i = 1'b0;
        #1;
        n_checks++; if (imem.req !== 1'b0 || valid_o !== 1'b0 || instruction_o !== 32'h0 || pc_add4_o !== 32'h0 || imem.addr !== 32'h0)
            $display("FAIL rmid_reset got=%0h/%0h/%h/%h/%h exp=0/0/0/0/0", imem.req, valid_o, instruction_o, pc_add4_o, imem.addr);
        else n_pass++;
        tick();
        rst_i = 1'b1;
        lat = 0;
        tick();
        n_checks++; if (valid_o !== 1'b1 || instruction_o !== memf(32'h0) || pc_add4_o !== 32'h4)
            $display("FAIL rmid_restart got=%0h/%h/%h exp=1/%h/00000004", valid_o, instruction_o, pc_add4_o, memf(32'h0));
        else n_pass++;
    endtask
    // Stream model: shown words must follow exp_pc; consumption advances it, redirects retarget it
    task automatic test_random();
        logic p_valid = 1'b0, p_hazard = 1'b0, p_redir = 1'b0, p_req = 1'b0, p_ack = 1'b0;
        logic [31:0] p_addr = 32'd0;
        int consumed = 0;
        rand_lat = 1'b1;
        exp_pc = 32'h0;
        for (int k = 0; k < 3000; k++) begin
            if (p_redir) begin
                n_checks++; if (valid_o !== 1'b0) $display("FAIL rnd_redir_valid cyc=%0d got=%0h exp=0", k, valid_o); else n_pass++;
            end
            if (p_valid && p_hazard && !p_redir) begin
                n_checks++; if (valid_o !== 1'b1) $display("FAIL rnd_hold_valid cyc=%0d got=%0h exp=1", k, valid_o); else n_pass++;
            end
            if (p_req && !p_ack) begin
                n_checks++; if (imem.req !== 1'b1 || imem.addr !== p_addr)
                    $display("FAIL rnd_req_stable cyc=%0d got=%0h/%h exp=1/%h", k, imem.req, imem.addr, p_addr);
                else n_pass++;
            end
            if (valid_o) begin
                n_checks++; if (instruction_o !== memf(exp_pc) || pc_add4_o !== exp_pc + 32'd4)
                    $display("FAIL rnd_word cyc=%0d got=%h/%h exp=%h/%h", k, instruction_o, pc_add4_o, memf(exp_pc), exp_pc + 32'd4);
                else n_pass++;
            end else begin
                n_checks++; if (instruction_o !== 32'h0) $display("FAIL rnd_nop cyc=%0d got=%h exp=0", k, instruction_o); else n_pass++;
            end
            hazard_i = ($urandom_range(0, 9) < 3);
            redirect_i = ($urandom_range(0, 19) == 0);
            redirect_pc_i = $urandom & 32'hFFFF_FFFC;
            if (redirect_i) exp_pc = redirect_pc_i;
            else if (valid_o && !hazard_i) begin
                exp_pc += 32'd4;
                consumed++;
            end
            p_valid = valid_o; p_hazard = hazard_i; p_redir = redirect_i;
            p_req = imem.req; p_addr = imem.addr;
            tick();
            p_ack = last_ack;
        end
        hazard_i = 1'b0; redirect_i = 1'b0;
        n_checks++; if (consumed < 200) $display("FAIL rnd_throughput got=%0d exp>=200", consumed); else n_pass++;
    endtask
    initial begin
        test_reset();
        test_stream();
        test_stall();
        test_latency();
        test_redirect_drain();
        test_redirect_hold();
        test_wrap();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
